hdmi_mode_ctrl: RTL
===================

# hdmi_mode_ctrl

Video-mode configuration controller for the HDMI pixel generator. It holds a staged set of horizontal and vertical timing registers and validates them on a commit request. A valid mode is applied only at a frame boundary: the controller holds the generator in reset while the active timing outputs change, so the generator never sees a mode change outside reset. It sits between the bus/control logic and the generator's `i_hm_*` / `i_vm_*` / `i_reset` inputs.

## Interface
- `HW`, 12: horizontal timing width; also width of `i_data`.
- `VW`, 12: vertical timing width; must satisfy `VW <= HW`.
- `DEF_HW, DEF_HP, DEF_HS, DEF_HR`, 640/656/752/800: reset horizontal mode (width, porch, synch, raw).
- `DEF_VH, DEF_VP, DEF_VS, DEF_VR`, 480/490/492/525: reset vertical mode (height, porch, synch, raw).
- `RST_CYCLES`, 4: generator reset hold length, must be >= 3.
- `TIMEOUT`, 2^20: maximum cycles spent waiting for a frame boundary.

Ports:
- `i_pixclk`  in  1  pixel clock; the only clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_wr`  in  1  staging register write strobe.
- `i_addr`  in  3  staging address: 0 hwidth, 1 hporch, 2 hsynch, 3 hraw, 4 vheight, 5 vporch, 6 vsynch, 7 vraw.
- `i_data`  in  HW  write data; vertical registers take `i_data[VW-1:0]`.
- `i_commit`  in  1  request to validate and apply the staged mode.
- `i_newframe`  in  1  frame-boundary pulse from the generator.
- `o_busy`  out  1  commit in progress.
- `o_err`  out  2  bit0 = invalid mode rejected; bit1 = switch forced by timeout.
- `o_gen_reset`  out  1  reset to the generator.
- `o_hm_width, o_hm_porch, o_hm_synch, o_hm_raw`  out  HW each  active horizontal mode.
- `o_vm_height, o_vm_porch, o_vm_synch, o_vm_raw`  out  VW each  active vertical mode.
- `o_switch_count`  out  8  number of completed mode switches; wraps 255 -> 0.

## Operation
- FSM states: IDLE, CHECK, WAIT_FRAME, HOLD.
- IDLE:
  - `i_wr` updates the addressed staging register.
  - `i_commit` goes to CHECK and clears `o_err`.
  - When `i_wr` and `i_commit` arrive in the same cycle, the write lands first and CHECK validates the written value.
- Writes and commits arriving in any state other than IDLE are dropped.
- CHECK (1 cycle) evaluates validity; all arithmetic is unsigned, and sums are computed in HW+1 bits (no wrap).
  - Horizontal: `16 < width < porch < synch < raw` and `porch + 14 < raw`.
  - Vertical: `16 < height < porch < synch < raw`.
  - Invalid: go to IDLE and set `o_err[0]`.
  - Valid: go to WAIT_FRAME and clear the timeout counter.
- WAIT_FRAME:
  - If `i_newframe` is seen, go to HOLD.
  - Otherwise, when the counter reaches `TIMEOUT-1`, go to HOLD and set `o_err[1]`.
  - If `i_newframe` and the timeout fall in the same cycle, treat it as a newframe; `o_err[1]` stays 0.
- HOLD:
  - `o_gen_reset` = 1 for exactly `RST_CYCLES` cycles.
  - Active outputs load the staged values on the entry edge.
  - On exit, go to IDLE and increment `o_switch_count` (except when HOLD was entered from reset).
- Reset:
  - Staging and active registers take the DEF_* values.
  - FSM enters HOLD with its counter cleared.
  - `o_busy` = 1, `o_gen_reset` = 1, `o_err` = 0, `o_switch_count` = 0.
  - Reset asserted mid-operation aborts any pending commit.

## Timing
- All outputs are registered.
- Commit accepted at edge N: `o_busy` = 1 from N+1 (CHECK).
  - Invalid mode: `o_busy` = 0 and `o_err[0]` = 1 at N+2.
  - Valid mode: WAIT_FRAME from N+2.
- `i_newframe` sampled high in WAIT_FRAME at edge M:
  - `o_gen_reset` rises and the active mode changes at M+1.
  - `o_gen_reset` falls at M+1+RST_CYCLES.
  - `o_busy` falls in that same cycle, and `o_switch_count` increments in that same cycle.
- The active mode outputs never change while `o_gen_reset` = 0.
- After `i_reset` drops at edge R: `o_gen_reset` and `o_busy` stay high through R+RST_CYCLES-1 and are low at R+RST_CYCLES.
- `i_newframe` outside WAIT_FRAME is ignored.

## Test plan
- Reset with no writes: outputs are 640/656/752/800, 480/490/492/525; `o_gen_reset` is high for 4 cycles after reset release; `o_switch_count` = 0.
- Write 1280/1390/1430/1650 and 720/725/730/750, commit, pulse `i_newframe` 100 cycles later: the outputs change on the cycle `o_gen_reset` rises; `o_gen_reset` is high for 4 cycles; `o_switch_count` = 1; `o_err` = 0.
- Write hporch = 600 (< width 640), commit: `o_err` = 01 two cycles after the commit; the active mode is unchanged; `o_gen_reset` never asserts.
- Set `TIMEOUT` = 64, commit a valid mode, hold `i_newframe` low: the switch is forced 64 cycles after entering WAIT_FRAME; `o_err` = 10.
- Commit, then write hraw and commit again while busy: both are ignored; the first mode applies at the next `i_newframe`.
- Assert `i_reset` during HOLD: the active mode returns to the defaults; `o_switch_count` = 0; a fresh 4-cycle hold follows release.

Source files
------------

// File: rtl/hdmi_mode_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_mode_ctrl
//
// Video-mode configuration controller for the HDMI pixel generator.
// The controller stages eight horizontal and vertical timing values. A commit
// request validates them. A valid mode is applied only at a frame boundary,
// or when a bounded wait for that boundary expires. While the active timing
// outputs change, the generator is held in reset.
//
// Ports
//   i_pixclk        pixel clock (only clock)
//   i_reset         synchronous active-high reset
//   i_wr            staging register write strobe (honoured in IDLE only)
//   i_addr          staging address 0..7 = hw, hp, hs, hr, vh, vp, vs, vr
//   i_data          write data; vertical registers take i_data[VW-1:0]
//   i_commit        validate-and-apply request (honoured in IDLE only)
//   i_newframe      frame-boundary pulse from the generator
//   o_busy          commit (or post-reset hold) in progress
//   o_err           bit0 invalid mode rejected, bit1 switch forced by timeout
//   o_gen_reset     reset to the generator
//   o_hm_*/o_vm_*   active horizontal / vertical mode
//   o_switch_count  completed mode switches, wraps at 255
// -----------------------------------------------------------------------------
module hdmi_mode_ctrl #(
    parameter int HW         = 12,
    parameter int VW         = 12,
    parameter int DEF_HW     = 640,
    parameter int DEF_HP     = 656,
    parameter int DEF_HS     = 752,
    parameter int DEF_HR     = 800,
    parameter int DEF_VH     = 480,
    parameter int DEF_VP     = 490,
    parameter int DEF_VS     = 492,
    parameter int DEF_VR     = 525,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1048576
) (
    input  logic          i_pixclk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [2:0]    i_addr,
    input  logic [HW-1:0] i_data,
    input  logic          i_commit,
    input  logic          i_newframe,
    output logic          o_busy,
    output logic [1:0]    o_err,
    output logic          o_gen_reset,
    output logic [HW-1:0] o_hm_width,
    output logic [HW-1:0] o_hm_porch,
    output logic [HW-1:0] o_hm_synch,
    output logic [HW-1:0] o_hm_raw,
    output logic [VW-1:0] o_vm_height,
    output logic [VW-1:0] o_vm_porch,
    output logic [VW-1:0] o_vm_synch,
    output logic [VW-1:0] o_vm_raw,
    output logic [7:0]    o_switch_count
);

    localparam int TMO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int HOLD_W = $clog2(RST_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_from_reset;   // current HOLD is the post-reset hold, not a switch
    logic              r_busy;
    logic [1:0]        r_err;
    logic              r_gen_reset;
    logic [7:0]        r_switch_count;

    // staged mode
    logic [HW-1:0] r_stg_hw, r_stg_hp, r_stg_hs, r_stg_hr;
    logic [VW-1:0] r_stg_vh, r_stg_vp, r_stg_vs, r_stg_vr;
    // active mode
    logic [HW-1:0] r_act_hw, r_act_hp, r_act_hs, r_act_hr;
    logic [VW-1:0] r_act_vh, r_act_vp, r_act_vs, r_act_vr;

    logic w_h_ok;
    logic w_v_ok;

    // Horizontal rule; the porch sum is one bit wider so it can never wrap.
    function automatic logic f_h_valid(input logic [HW-1:0] w, input logic [HW-1:0] p,
                                       input logic [HW-1:0] s, input logic [HW-1:0] r);
        logic [HW:0] p_plus;
        p_plus = {1'b0, p} + (HW+1)'(14);
        return (w > HW'(16)) && (w < p) && (p < s) && (s < r) && (p_plus < {1'b0, r});
    endfunction

    // Vertical rule.
    function automatic logic f_v_valid(input logic [VW-1:0] h, input logic [VW-1:0] p,
                                       input logic [VW-1:0] s, input logic [VW-1:0] r);
        return (h > VW'(16)) && (h < p) && (p < s) && (s < r);
    endfunction

    assign w_h_ok = f_h_valid(r_stg_hw, r_stg_hp, r_stg_hs, r_stg_hr);
    assign w_v_ok = f_v_valid(r_stg_vh, r_stg_vp, r_stg_vs, r_stg_vr);

    // Controller FSM, staging/active registers and all registered outputs.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            r_state        <= S_HOLD;
            r_tmo_cnt      <= '0;
            r_hold_cnt     <= '0;
            r_from_reset   <= 1'b1;
            r_busy         <= 1'b1;
            r_err          <= 2'b00;
            r_gen_reset    <= 1'b1;
            r_switch_count <= 8'd0;
            r_stg_hw <= HW'(DEF_HW); r_stg_hp <= HW'(DEF_HP);
            r_stg_hs <= HW'(DEF_HS); r_stg_hr <= HW'(DEF_HR);
            r_stg_vh <= VW'(DEF_VH); r_stg_vp <= VW'(DEF_VP);
            r_stg_vs <= VW'(DEF_VS); r_stg_vr <= VW'(DEF_VR);
            r_act_hw <= HW'(DEF_HW); r_act_hp <= HW'(DEF_HP);
            r_act_hs <= HW'(DEF_HS); r_act_hr <= HW'(DEF_HR);
            r_act_vh <= VW'(DEF_VH); r_act_vp <= VW'(DEF_VP);
            r_act_vs <= VW'(DEF_VS); r_act_vr <= VW'(DEF_VR);
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A write in the commit cycle lands before CHECK reads the stage.
                    if (i_wr) begin
                        case (i_addr)
                            3'd0:    r_stg_hw <= i_data;
                            3'd1:    r_stg_hp <= i_data;
                            3'd2:    r_stg_hs <= i_data;
                            3'd3:    r_stg_hr <= i_data;
                            3'd4:    r_stg_vh <= i_data[VW-1:0];
                            3'd5:    r_stg_vp <= i_data[VW-1:0];
                            3'd6:    r_stg_vs <= i_data[VW-1:0];
                            3'd7:    r_stg_vr <= i_data[VW-1:0];
                            default: r_stg_hw <= r_stg_hw;
                        endcase
                    end
                    if (i_commit) begin
                        r_state <= S_CHECK;
                        r_busy  <= 1'b1;
                        r_err   <= 2'b00;
                    end
                end
                S_CHECK: begin
                    if (w_h_ok && w_v_ok) begin
                        r_state   <= S_WAIT;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_err[0] <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // A frame boundary on the timeout cycle counts as a normal switch.
                    if (i_newframe || (r_tmo_cnt == TMO_LAST)) begin
                        if (!i_newframe) begin
                            r_err[1] <= 1'b1;
                        end
                        r_state      <= S_HOLD;
                        r_hold_cnt   <= '0;
                        r_gen_reset  <= 1'b1;
                        r_from_reset <= 1'b0;
                        // Active mode changes on the same edge gen_reset rises.
                        r_act_hw <= r_stg_hw; r_act_hp <= r_stg_hp;
                        r_act_hs <= r_stg_hs; r_act_hr <= r_stg_hr;
                        r_act_vh <= r_stg_vh; r_act_vp <= r_stg_vp;
                        r_act_vs <= r_stg_vs; r_act_vr <= r_stg_vr;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= S_IDLE;
                        r_gen_reset <= 1'b0;
                        r_busy      <= 1'b0;
                        if (!r_from_reset) begin
                            r_switch_count <= r_switch_count + 8'd1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_gen_reset <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_err          = r_err;
    assign o_gen_reset    = r_gen_reset;
    assign o_switch_count = r_switch_count;
    assign o_hm_width     = r_act_hw;
    assign o_hm_porch     = r_act_hp;
    assign o_hm_synch     = r_act_hs;
    assign o_hm_raw       = r_act_hr;
    assign o_vm_height    = r_act_vh;
    assign o_vm_porch     = r_act_vp;
    assign o_vm_synch     = r_act_vs;
    assign o_vm_raw       = r_act_vr;

endmodule
